multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. Sequences instruction fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select from the opcode/funct fields produced by the instruction decoder. Sits between the instruction register/decoder outputs and the PC, ALU, register file and memory interfaces. One instruction in flight at a time; no pipelining.

---
 rtl/multicycle_ctrl_if.sv | 39 +++
 rtl/multicycle_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and the RV32I datapath.
//   master : controller side (drives enables, selects, memory requests, debug state)
//   slave  : datapath/memory side (drives decoder fields, comparator flags, acks, run)
interface multicycle_ctrl_if;
    logic       run;
    logic [6:0] cmdOp;
    logic [2:0] cmdF3;
    logic [6:0] cmdF7;
    logic       alu_zero;
    logic       alu_lt;
    logic       alu_ltu;
    logic       imem_req;
    logic       imem_ack;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       illegal;
    logic [2:0] state;

    modport master (
        input  run, cmdOp, cmdF3, cmdF7, alu_zero, alu_lt, alu_ltu, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
               alu_op, rf_we, wb_sel, illegal, state
    );

    modport slave (
        output run, cmdOp, cmdF3, cmdF7, alu_zero, alu_lt, alu_ltu, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
               alu_op, rf_we, wb_sel, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH/IDLE.
// One instruction in flight. Datapath enables/selects are decoded from the current state, the
// instruction class latched in DECODE and the live ack/comparator inputs.
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    multicycle_ctrl_if.master (decoder fields, flags, memory handshakes, datapath controls)
// Build option:
//   MCTRL_ILLEGAL_TRAP_EN  defined: illegal encodings enter TRAP (sticky until reset, illegal=1).
//                          undefined: illegal encodings retire as a NOP, illegal stays 0.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned ALUOP_W = 4;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

    localparam logic [OPC_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [OPC_W-1:0] F7_ALT  = 7'b0100000;

    localparam logic [ALUOP_W-1:0] ALU_ADD    = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALU_PASS_B = 4'b1111;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_REL  = 2'b01;
    localparam logic [1:0] PC_JALR = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        C_NONE,
        C_OP,
        C_OPIMM,
        C_LOAD,
        C_STORE,
        C_LUI,
        C_AUIPC,
        C_BRANCH,
        C_JAL,
        C_JALR
    } cls_e;

    state_e            state_q;
    cls_e              cls_q;
    logic [F3_W-1:0]   f3_q;
    logic              alt_q;
    logic              illegal_q;

    cls_e              dec_cls;
    logic              dec_legal;
    logic              br_taken;
    state_e            boundary_s;

    // Instruction class and legality from the live decoder fields (sampled in DECODE).
    always_comb begin
        dec_cls   = C_NONE;
        dec_legal = 1'b0;
        case (bus.cmdOp)
            OPC_OP: begin
                dec_cls   = C_OP;
                dec_legal = (bus.cmdF7 == F7_BASE) ||
                            ((bus.cmdF7 == F7_ALT) &&
                             ((bus.cmdF3 == 3'b000) || (bus.cmdF3 == 3'b101)));
            end
            OPC_OPIMM: begin
                dec_cls = C_OPIMM;
                if (bus.cmdF3 == 3'b001) begin
                    dec_legal = (bus.cmdF7 == F7_BASE);
                end else if (bus.cmdF3 == 3'b101) begin
                    dec_legal = (bus.cmdF7 == F7_BASE) || (bus.cmdF7 == F7_ALT);
                end else begin
                    dec_legal = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec_cls   = C_LOAD;
                dec_legal = 1'b1;
            end
            OPC_STORE: begin
                dec_cls   = C_STORE;
                dec_legal = 1'b1;
            end
            OPC_LUI: begin
                dec_cls   = C_LUI;
                dec_legal = 1'b1;
            end
            OPC_AUIPC: begin
                dec_cls   = C_AUIPC;
                dec_legal = 1'b1;
            end
            OPC_BRANCH: begin
                dec_cls   = C_BRANCH;
                dec_legal = (bus.cmdF3 != 3'b010) && (bus.cmdF3 != 3'b011);
            end
            OPC_JAL: begin
                dec_cls   = C_JAL;
                dec_legal = 1'b1;
            end
            OPC_JALR: begin
                dec_cls   = C_JALR;
                dec_legal = (bus.cmdF3 == 3'b000);
            end
            default: begin
                dec_cls   = C_NONE;
                dec_legal = 1'b0;
            end
        endcase
    end

    // Branch condition from the comparator flags, selected by the latched funct3.
    always_comb begin
        br_taken = 1'b0;
        case (f3_q)
            3'b000:  br_taken = bus.alu_zero;
            3'b001:  br_taken = !bus.alu_zero;
            3'b100:  br_taken = bus.alu_lt;
            3'b101:  br_taken = !bus.alu_lt;
            3'b110:  br_taken = bus.alu_ltu;
            3'b111:  br_taken = !bus.alu_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // Where an instruction goes when it retires.
    assign boundary_s = bus.run ? S_FETCH : S_IDLE;

    // State sequencing plus the instruction fields captured in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cls_q     <= C_NONE;
            f3_q      <= '0;
            alt_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.run) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    cls_q <= dec_cls;
                    f3_q  <= bus.cmdF3;
                    alt_q <= bus.cmdF7[5];
                    if (dec_legal) begin
                        state_q <= S_EXEC;
                    end else begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
                        state_q   <= S_TRAP;
                        illegal_q <= 1'b1;
`else
                        state_q   <= boundary_s;
`endif
                    end
                end
                S_EXEC: begin
                    case (cls_q)
                        C_LOAD, C_STORE: state_q <= S_MEM;
                        C_BRANCH:        state_q <= boundary_s;
                        default:         state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        state_q <= (cls_q == C_LOAD) ? S_WB : boundary_s;
                    end
                end
                S_WB: begin
                    state_q <= boundary_s;
                end
                S_TRAP: begin
                    state_q <= S_TRAP;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic                imem_req_c;
    logic                dmem_req_c;
    logic                dmem_we_c;
    logic                ir_we_c;
    logic                pc_we_c;
    logic [1:0]          pc_src_c;
    logic                alu_src_a_c;
    logic                alu_src_b_c;
    logic [ALUOP_W-1:0]  alu_op_c;
    logic                rf_we_c;
    logic [1:0]          wb_sel_c;

    // Datapath controls; everything idles at 0 outside the states that need it.
    always_comb begin
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        pc_src_c    = PC_SEQ;
        alu_src_a_c = 1'b0;
        alu_src_b_c = 1'b0;
        alu_op_c    = ALU_ADD;
        rf_we_c     = 1'b0;
        wb_sel_c    = WB_ALU;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                // IR and PC+4 are committed on the edge that sees the fetch ack.
                if (bus.imem_ack) begin
                    ir_we_c  = 1'b1;
                    pc_we_c  = 1'b1;
                    pc_src_c = PC_SEQ;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_OP: begin
                        alu_op_c = {alt_q, f3_q};
                    end
                    C_OPIMM: begin
                        // Only SRAI/SRLI use funct7[5]; ADDI etc. must never become SUB.
                        alu_src_b_c = 1'b1;
                        alu_op_c    = {(f3_q == 3'b101) & alt_q, f3_q};
                    end
                    C_LOAD, C_STORE: begin
                        alu_src_b_c = 1'b1;
                        alu_op_c    = ALU_ADD;
                    end
                    C_LUI: begin
                        alu_src_b_c = 1'b1;
                        alu_op_c    = ALU_PASS_B;
                    end
                    C_AUIPC: begin
                        alu_src_a_c = 1'b1;
                        alu_src_b_c = 1'b1;
                        alu_op_c    = ALU_ADD;
                    end
                    C_BRANCH: begin
                        if (br_taken) begin
                            pc_we_c  = 1'b1;
                            pc_src_c = PC_REL;
                        end
                    end
                    C_JAL: begin
                        pc_we_c  = 1'b1;
                        pc_src_c = PC_REL;
                    end
                    C_JALR: begin
                        pc_we_c  = 1'b1;
                        pc_src_c = PC_JALR;
                    end
                    default: begin
                        pc_we_c = 1'b0;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (cls_q == C_STORE);
            end
            S_WB: begin
                rf_we_c = 1'b1;
                if (cls_q == C_LOAD) begin
                    wb_sel_c = WB_LOAD;
                end else if ((cls_q == C_JAL) || (cls_q == C_JALR)) begin
                    wb_sel_c = WB_LINK;
                end else begin
                    wb_sel_c = WB_ALU;
                end
            end
            default: begin
                imem_req_c = 1'b0;
            end
        endcase
    end

    assign bus.imem_req  = imem_req_c;
    assign bus.dmem_req  = dmem_req_c;
    assign bus.dmem_we   = dmem_we_c;
    assign bus.ir_we     = ir_we_c;
    assign bus.pc_we     = pc_we_c;
    assign bus.pc_src    = pc_src_c;
    assign bus.alu_src_a = alu_src_a_c;
    assign bus.alu_src_b = alu_src_b_c;
    assign bus.alu_op    = alu_op_c;
    assign bus.rf_we     = rf_we_c;
    assign bus.wb_sel    = wb_sel_c;
    // Never set when illegal encodings retire as NOPs, so this folds to a constant 0.
    assign bus.illegal   = illegal_q;
    assign bus.state     = 3'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction stream against a per-instruction cycle-list reference model.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus_if();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_idx  = 0;

    // One expected cycle: required outputs plus the inputs the bench applies that cycle.
    typedef struct packed {
        logic [19:0] exp;
        logic        run;
        logic        ia;
        logic        da;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        logic        lt;
        logic        ltu;
    } cyc_t;

    cyc_t cq[$];

    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] cur_f7;
    logic       cur_z, cur_lt, cur_ltu;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] mk(input logic [2:0] st, input logic ill, input logic imr,
                                       input logic dmr, input logic dwe, input logic irw,
                                       input logic pcw, input logic [1:0] ps, input logic sa,
                                       input logic sb, input logic [3:0] aop, input logic rfw,
                                       input logic [1:0] wbs);
        return {st, ill, imr, dmr, dwe, irw, pcw, ps, sa, sb, aop, rfw, wbs};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {bus_if.state, bus_if.illegal, bus_if.imem_req, bus_if.dmem_req, bus_if.dmem_we,
                bus_if.ir_we, bus_if.pc_we, bus_if.pc_src, bus_if.alu_src_a, bus_if.alu_src_b,
                bus_if.alu_op, bus_if.rf_we, bus_if.wb_sel};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Legality rules for RV32I encodings handled by this controller.
    function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        case (op)
            OP_R:   return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            OP_I:   return (f3 == 3'd1) ? (f7 == 7'h00) :
                           (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
            OP_LD, OP_ST, OP_LUI, OP_AUI, OP_JAL: return 1'b1;
            OP_BR:  return (f3 != 3'd2) && (f3 != 3'd3);
            OP_JR:  return f3 == 3'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit branch_taken(input logic [2:0] f3, input logic z, input logic lt,
                                        input logic ltu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return ltu;
            default: return !ltu;
        endcase
    endfunction

    task automatic push(input logic [19:0] e, input logic r, input logic ia, input logic da,
                        input bit garbage);
        cyc_t c;
        c.exp = e;
        c.run = r;
        c.ia  = ia;
        c.da  = da;
        if (garbage) begin
            c.op = 7'($urandom);
            c.f3 = 3'($urandom);
            c.f7 = 7'($urandom);
        end else begin
            c.op = cur_op;
            c.f3 = cur_f3;
            c.f7 = cur_f7;
        end
        c.z   = cur_z;
        c.lt  = cur_lt;
        c.ltu = cur_ltu;
        cq.push_back(c);
    endtask

    // Retirement: either straight on to the next fetch, or a stay in IDLE until run returns.
    task automatic boundary(input bit stop);
        if (stop) begin
            repeat ($urandom_range(1, 3)) push(20'h0, 1'b0, rb(), rb(), 1'b1);
            push(20'h0, 1'b1, rb(), rb(), 1'b1);
        end
    endtask

    task automatic start_from_idle();
        push(20'h0, 1'b1, rb(), rb(), 1'b1);
    endtask

    // Expected cycle list for one instruction, starting at its first FETCH cycle.
    task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input logic lt, input logic ltu,
                             input int fw, input int mw, input bit stop, output bit trapped);
        logic       r;
        logic [1:0] wbs;
        bit         to_mem;
        bit         to_wb;
        logic [19:0] ex;
        trapped = 1'b0;
        r       = !stop;
        cur_op  = op;
        cur_f3  = f3;
        cur_f7  = f7;
        cur_z   = z;
        cur_lt  = lt;
        cur_ltu = ltu;
        for (int i = 0; i < fw; i++) push(mk(3'd1,0,1,0,0,0,0,2'd0,0,0,4'd0,0,2'd0), 1'b1, 1'b0, rb(), 1'b1);
        push(mk(3'd1,0,1,0,0,1,1,2'd0,0,0,4'd0,0,2'd0), 1'b1, 1'b1, rb(), 1'b1);
        push(20'h0 | mk(3'd2,0,0,0,0,0,0,2'd0,0,0,4'd0,0,2'd0), r, rb(), rb(), 1'b0);
        if (!is_legal(op, f3, f7)) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
            repeat (4) push(mk(3'd6,1,0,0,0,0,0,2'd0,0,0,4'd0,0,2'd0), rb(), rb(), rb(), 1'b0);
            trapped = 1'b1;
`else
            boundary(stop);
`endif
            return;
        end
        to_mem = 1'b0;
        to_wb  = 1'b1;
        wbs    = 2'd0;
        ex     = mk(3'd3,0,0,0,0,0,0,2'd0,0,0,4'd0,0,2'd0);
        case (op)
            OP_R:   ex = mk(3'd3,0,0,0,0,0,0,2'd0,0,0,{f7[5],f3},0,2'd0);
            OP_I:   ex = mk(3'd3,0,0,0,0,0,0,2'd0,0,1,{(f3 == 3'd5) ? f7[5] : 1'b0, f3},0,2'd0);
            OP_LD:  begin ex = mk(3'd3,0,0,0,0,0,0,2'd0,0,1,4'd0,0,2'd0); to_mem = 1'b1; wbs = 2'd1; end
            OP_ST:  begin ex = mk(3'd3,0,0,0,0,0,0,2'd0,0,1,4'd0,0,2'd0); to_mem = 1'b1; to_wb = 1'b0; end
            OP_LUI: ex = mk(3'd3,0,0,0,0,0,0,2'd0,0,1,4'hF,0,2'd0);
            OP_AUI: ex = mk(3'd3,0,0,0,0,0,0,2'd0,1,1,4'd0,0,2'd0);
            OP_BR:  begin
                to_wb = 1'b0;
                if (branch_taken(f3, z, lt, ltu)) ex = mk(3'd3,0,0,0,0,0,1,2'd1,0,0,4'd0,0,2'd0);
            end
            OP_JAL: begin ex = mk(3'd3,0,0,0,0,0,1,2'd1,0,0,4'd0,0,2'd0); wbs = 2'd2; end
            default: begin ex = mk(3'd3,0,0,0,0,0,1,2'd2,0,0,4'd0,0,2'd0); wbs = 2'd2; end
        endcase
        push(ex, r, rb(), rb(), 1'b0);
        if (to_mem) begin
            for (int i = 0; i < mw; i++)
                push(mk(3'd4,0,0,1,(op == OP_ST),0,0,2'd0,0,0,4'd0,0,2'd0), r, rb(), 1'b0, 1'b0);
            push(mk(3'd4,0,0,1,(op == OP_ST),0,0,2'd0,0,0,4'd0,0,2'd0), r, rb(), 1'b1, 1'b0);
        end
        if (to_wb) push(mk(3'd5,0,0,0,0,0,0,2'd0,0,0,4'd0,1,wbs), r, rb(), rb(), 1'b0);
        boundary(stop);
    endtask

    // Apply queued cycles: drive just after the rising edge, compare on the falling edge.
    task automatic run_queue(input int n);
        int k = 0;
        while (cq.size() > 0 && (n < 0 || k < n)) begin
            cyc_t c = cq.pop_front();
            bus_if.run      = c.run;
            bus_if.imem_ack = c.ia;
            bus_if.dmem_ack = c.da;
            bus_if.cmdOp    = c.op;
            bus_if.cmdF3    = c.f3;
            bus_if.cmdF7    = c.f7;
            bus_if.alu_zero = c.z;
            bus_if.alu_lt   = c.lt;
            bus_if.alu_ltu  = c.ltu;
            @(negedge clk);
            check($sformatf("cyc%0d_st%0d", cyc_idx, c.exp[19:17]), 32'(dut_vec()), 32'(c.exp));
            @(posedge clk);
            #1;
            cyc_idx++;
            k++;
        end
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus_if.run      = 1'b0;
        bus_if.imem_ack = 1'b0;
        bus_if.dmem_ack = 1'b0;
        #1;
        check("rst_outputs", 32'(dut_vec()), 32'h0);
        check("rst_dmem_req", 32'(bus_if.dmem_req), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic z, input logic lt, input logic ltu,
                            input int fw, input int mw, input bit stop);
        bit trapped;
        gen_instr(op, f3, f7, z, lt, ltu, fw, mw, stop, trapped);
        run_queue(-1);
        if (trapped) begin
            do_reset();
            start_from_idle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [11];
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         trapped;
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_LUI, OP_AUI, OP_BR, OP_JAL, OP_JR, 7'h7F, 7'h00};
        bus_if.run      = 1'b0;
        bus_if.imem_ack = 1'b0;
        bus_if.dmem_ack = 1'b0;
        bus_if.cmdOp    = '0;
        bus_if.cmdF3    = '0;
        bus_if.cmdF7    = '0;
        bus_if.alu_zero = 1'b0;
        bus_if.alu_lt   = 1'b0;
        bus_if.alu_ltu  = 1'b0;
        cur_op = '0; cur_f3 = '0; cur_f7 = '0; cur_z = 1'b0; cur_lt = 1'b0; cur_ltu = 1'b0;
        #1;
        do_reset();
        start_from_idle();

        // Directed cases.
        do_instr(OP_R,  3'd0, 7'h00, 0, 0, 0, 0, 0, 0);   // ADD, zero-wait fetch
        do_instr(OP_LD, 3'd2, 7'h00, 0, 0, 0, 0, 3, 0);   // LW with 3 data wait cycles
        do_instr(OP_BR, 3'd0, 7'h00, 1, 0, 0, 0, 0, 0);   // BEQ taken
        do_instr(OP_BR, 3'd0, 7'h00, 0, 0, 0, 0, 0, 0);   // BEQ not taken
        do_instr(OP_JR, 3'd0, 7'h00, 0, 0, 0, 1, 0, 0);   // JALR
        do_instr(OP_ST, 3'd2, 7'h00, 0, 0, 0, 0, 2, 1);   // SW, then stop at boundary
        do_instr(7'h7F, 3'd0, 7'h00, 0, 0, 0, 0, 0, 0);   // undefined opcode
        do_instr(OP_I,  3'd5, 7'h20, 0, 0, 0, 0, 0, 0);   // SRAI

        // Randomized stream.
        for (int n = 0; n < 250; n++) begin
            op = ops[$urandom_range(0, 10)];
            if (op == 7'h00) op = 7'($urandom);
            f3 = 3'($urandom);
            if (op == OP_JR && $urandom_range(0, 3) != 0) f3 = 3'd0;
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            do_instr(op, f3, f7, rb(), rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 3),
                     ($urandom_range(0, 7) == 0));
        end

        // Reset in the middle of a data-memory wait, then stay idle with run low.
        gen_instr(OP_LD, 3'd2, 7'h00, 0, 0, 0, 0, 6, 0, trapped);
        run_queue(6);
        cq.delete();
        do_reset();
        repeat (5) push(20'h0, 1'b0, rb(), rb(), 1'b1);
        run_queue(-1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
